audio_rx: RTL and testbench
===========================

AUDIO_RX -- requirements
Module: audio_rx

Interface
REQ-001 Parameter WORD_BITS, 16, bits per channel word; MSB first.
REQ-002 Parameter VOICE_THRESH, 16'd4096, magnitude above which a sample counts as voice.
REQ-003 Port clk  input  1  system clock from the crystal; all logic is on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port au_bck  input  1  external bit clock, asynchronous to clk, at most clk/8.
REQ-006 Port au_ws  input  1  word select, asynchronous; 0 = left word, 1 = right word.
REQ-007 Port au_data  input  1  serial sample data, asynchronous.
REQ-008 Port audio_left  output  16  last complete left sample, two's complement.
REQ-009 Port audio_right  output  16  last complete right sample, two's complement.
REQ-010 Port sample_valid  output  1  one-clk pulse: new left/right pair on the outputs.
REQ-011 Port frame_err  output  1  one-clk pulse: a word ended with a wrong bit count.
REQ-012 Port voice  output  1  level: |left| or |right| of last pair > VOICE_THRESH.

Function
REQ-013 au_bck, au_ws and au_data SHALL each pass through a 2-flop synchronizer, plus one extra register used for edge detection.
REQ-014 Bit capture: on each detected rising edge of the synchronized au_bck, the synchronized au_data SHALL shift into a 16-bit shift register, MSB first.
REQ-015 Frame format: left-justified, no one-bit delay; the first bit of a word is the first bck rise after a ws transition.
REQ-016 Bit counter: 0..WORD_BITS, saturating; cleared on each ws edge; bits beyond WORD_BITS are ignored and the register holds the first 16 bits.
REQ-017 FSM SHALL have three states: IDLE, LEFT, RIGHT.
REQ-018 FSM transitions: IDLE->LEFT on the first ws falling edge; IDLE ignores a ws rising edge; LEFT->RIGHT on a ws rising edge; RIGHT->LEFT on a ws falling edge.
REQ-019 LEFT->RIGHT with count == WORD_BITS: the shift register SHALL load into a pending-left holding register.
REQ-020 RIGHT->LEFT with count == WORD_BITS and pending-left valid: audio_left and audio_right SHALL update together, and sample_valid SHALL pulse in the same clk.
REQ-021 Word end with count < WORD_BITS SHALL pulse frame_err, SHALL discard that word, and SHALL clear pending-left valid; the outputs keep their old values.
REQ-022 Latency: a raw au_ws edge at clk edge N SHALL give sample_valid high for exactly the clk after edge N+3.
REQ-023 A bck rising edge and a ws edge detected in the same clk: the ws edge SHALL be handled first (counter cleared), then the bit is captured as bit 0 of the new word.
REQ-024 Magnitude rule: the magnitude of 16'h8000 SHALL saturate to 16'h7FFF.
REQ-025 voice SHALL update only with sample_valid, in the same clk, as a registered compare of both channels against VOICE_THRESH.
REQ-026 No bck edges: the FSM SHALL hold its state indefinitely, and no timeout exists.

Reset
REQ-027 While rst=1 at a clk edge: the FSM goes to IDLE; the shift register, counter, pending register and all synchronizer flops clear to 0.
REQ-028 Reset values of outputs: audio_left=0, audio_right=0, sample_valid=0, frame_err=0, voice=0.
REQ-029 Reset mid-word SHALL abandon the word with no frame_err; capture restarts at the next ws falling edge.

Structure
REQ-030 Shared package audio_pkg SHALL hold the WORD_BITS default, the FSM state encoding (IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2) and the VOICE_THRESH default.
REQ-031 A single sub-module, audio_sync_edge, SHALL be instantiated three times: 2-flop synchronizer plus rise/fall pulse outputs.
REQ-032 The FSM, counter, shift register and level compare SHALL live in audio_rx itself.

Verification
REQ-033 Reset, then frame L=16'h1234, R=16'hABCD at bck = clk/8 -> one sample_valid; audio_left=16'h1234, audio_right=16'hABCD; voice=1.
REQ-034 Frame L=16'h0010, R=16'hFFF0 -> voice=0. Then L=16'h8000 -> magnitude 16'h7FFF, voice=1.
REQ-035 Left word with only 12 bck rises -> frame_err pulse at the LEFT->RIGHT transition; no sample_valid for that frame; outputs unchanged.
REQ-036 Right word with 20 bck rises, first 16 bits = 16'h5A5A -> audio_right=16'h5A5A; no frame_err.
REQ-037 Start stimulus with ws=1 mid-right-word -> nothing until the first ws fall; the first full frame after that is the first output.
REQ-038 Assert rst for 1 clk mid-left-word -> all outputs 0 and FSM IDLE; the next complete frame decodes correctly with no frame_err.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared defaults and FSM encoding for the serial audio receiver.
package audio_pkg;

  localparam int          WORD_BITS_DEF    = 16;
  localparam logic [15:0] VOICE_THRESH_DEF = 16'd4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/audio_sync_edge.sv
// Two-flop synchronizer plus one history flop; rise/fall are one-clk pulses.
// Latency: async change to pulse is two clk edges; no backpressure.
module audio_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/audio_rx.sv
// Left-justified serial audio receiver: captures L/R words, emits pairs and a voice flag.
// Latency: raw ws edge to sample_valid is three clk edges; no backpressure (free-running).
module audio_rx
  import audio_pkg::*;
#(
  parameter int                   WORD_BITS    = WORD_BITS_DEF,
  parameter logic [WORD_BITS-1:0] VOICE_THRESH = VOICE_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 au_bck,
  input  logic                 au_ws,
  input  logic                 au_data,
  output logic [WORD_BITS-1:0] audio_left,
  output logic [WORD_BITS-1:0] audio_right,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic                 voice
);

  localparam int             CW   = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0]  FULL = CW'(WORD_BITS);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic bck_rise, ws_rise, ws_fall, data_s;
  logic unused_bck_sync, unused_bck_fall, unused_ws_sync;
  logic unused_data_rise, unused_data_fall;

  audio_sync_edge u_sync_bck (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (au_bck),
    .sync_o  (unused_bck_sync),
    .rise_o  (bck_rise),
    .fall_o  (unused_bck_fall)
  );

  audio_sync_edge u_sync_ws (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (au_ws),
    .sync_o  (unused_ws_sync),
    .rise_o  (ws_rise),
    .fall_o  (ws_fall)
  );

  audio_sync_edge u_sync_data (
    .clk_i   (clk),
    .rst_i   (rst),
    .async_i (au_data),
    .sync_o  (data_s),
    .rise_o  (unused_data_rise),
    .fall_o  (unused_data_fall)
  );

  // Most negative code has no positive twin, so it saturates to max positive.
  function automatic logic [WORD_BITS-1:0] magnitude(input logic [WORD_BITS-1:0] s);
    logic [WORD_BITS-1:0] neg;
    neg = ~s + {{(WORD_BITS-1){1'b0}}, 1'b1};
    if (!s[WORD_BITS-1]) return s;
    if (neg[WORD_BITS-1]) return {1'b0, {(WORD_BITS-1){1'b1}}};
    return neg;
  endfunction

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_base;
  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic [WORD_BITS-1:0] pend_q, pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [WORD_BITS-1:0] left_q, left_d, right_q, right_d;
  logic                 valid_q, valid_d, ferr_q, ferr_d, voice_q, voice_d;
  logic                 ws_edge, word_full;

  assign ws_edge   = ws_rise | ws_fall;
  assign word_full = (cnt_q == FULL);

  // A ws edge closes the old word before a coincident bck rise opens the new one.
  always_comb begin
    cnt_base = ws_edge ? '0 : cnt_q;
    cnt_d    = cnt_base;
    sh_d     = sh_q;
    if (bck_rise && (cnt_base != FULL)) begin
      sh_d  = {sh_q[WORD_BITS-2:0], data_s};
      cnt_d = cnt_base + ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    voice_d    = voice_q;
    case (state_q)
      IDLE: begin
        if (ws_fall) state_d = LEFT;
      end
      LEFT: begin
        if (ws_rise) begin
          state_d = RIGHT;
          if (word_full) begin
            pend_d     = sh_q;
            pend_vld_d = 1'b1;
          end else begin
            ferr_d     = 1'b1;
            pend_vld_d = 1'b0;
          end
        end
      end
      RIGHT: begin
        if (ws_fall) begin
          state_d    = LEFT;
          pend_vld_d = 1'b0;
          if (!word_full) begin
            ferr_d = 1'b1;
          end else if (pend_vld_q) begin
            left_d  = pend_q;
            right_d = sh_q;
            valid_d = 1'b1;
            voice_d = (magnitude(pend_q) > VOICE_THRESH) ||
                      (magnitude(sh_q) > VOICE_THRESH);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      voice_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      voice_q    <= voice_d;
    end
  end

  assign audio_left   = left_q;
  assign audio_right  = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;
  assign voice        = voice_q;

endmodule

// File: tb/tb_audio_rx.sv
// Directed bench for audio_rx: serial frames at bck = clk/8, pairs checked through a scoreboard.
module tb_audio_rx;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        au_bck = 1'b0;
  logic        au_ws = 1'b1;
  logic        au_data = 1'b0;
  logic [15:0] audio_left, audio_right;
  logic        sample_valid, frame_err, voice;

  audio_rx dut (
    .clk          (clk),
    .rst          (rst),
    .au_bck       (au_bck),
    .au_ws        (au_ws),
    .au_data      (au_data),
    .audio_left   (audio_left),
    .audio_right  (audio_right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err),
    .voice        (voice)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   fe_cnt = 0;
  int   cyc = 0;
  int   ws_fall_cyc = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mag(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7FFF;
    if (x[15]) return 16'(-$signed(x));
    return x;
  endfunction

  function automatic exp_t mk(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.l = l;
    e.r = r;
    e.v = (ref_mag(l) > 16'd4096) || (ref_mag(r) > 16'd4096);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (sample_valid) begin
        exp_t e;
        check("valid_one_clk", 32'(prev_valid), 32'd0);
        check("valid_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("left", 32'(audio_left), 32'(e.l));
          check("right", 32'(audio_right), 32'(e.r));
          check("voice", 32'(voice), 32'(e.v));
          check("latency", 32'(cyc - ws_fall_cyc), 32'd3);
        end
      end
    end
    prev_valid = sample_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_ws(input logic v);
    if (au_ws && !v) ws_fall_cyc = cyc;
    au_ws = v;
  endtask

  // ws normally changes with bck low; 'together' moves it onto bit 0's bck rise.
  task automatic send_word(input logic ws_v, input logic [15:0] val, input int nbits,
                           input bit together);
    for (int i = 0; i < nbits; i++) begin
      au_bck  = 1'b0;
      au_data = (i < 16) ? val[15-i] : 1'($urandom);
      if (i == 0 && !together) drive_ws(ws_v);
      tick(4);
      au_bck = 1'b1;
      if (i == 0 && together) drive_ws(ws_v);
      tick(4);
    end
  endtask

  initial begin
    tick(4);
    check("rst_left", 32'(audio_left), 32'd0);
    check("rst_right", 32'(audio_right), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_voice", 32'(voice), 32'd0);
    rst = 1'b0;

    // start mid-right-word: nothing may happen until the first ws fall
    send_word(1'b1, 16'hC3C3, 8, 1'b0);
    check("idle_no_ferr", 32'(fe_cnt), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(IDLE));

    send_word(1'b0, 16'h1234, 16, 1'b0);
    sb.push_back(mk(16'h1234, 16'hABCD));
    send_word(1'b1, 16'hABCD, 16, 1'b0);

    send_word(1'b0, 16'h0010, 16, 1'b0);
    sb.push_back(mk(16'h0010, 16'hFFF0));
    send_word(1'b1, 16'hFFF0, 16, 1'b0);

    send_word(1'b0, 16'h8000, 16, 1'b0);
    sb.push_back(mk(16'h8000, 16'h0000));
    send_word(1'b1, 16'h0000, 16, 1'b0);

    // short left word: error at LEFT->RIGHT, frame dropped
    send_word(1'b0, 16'h0FFF, 12, 1'b0);
    send_word(1'b1, 16'h1111, 16, 1'b0);
    check("short_ferr", 32'(fe_cnt), 32'd1);
    send_word(1'b0, 16'h2222, 16, 1'b0);
    check("short_keep_left", 32'(audio_left), 32'h8000);
    check("short_keep_right", 32'(audio_right), 32'h0000);
    check("short_keep_voice", 32'(voice), 32'd1);

    // long right word: extra bits ignored
    sb.push_back(mk(16'h2222, 16'h5A5A));
    send_word(1'b1, 16'h5A5A, 20, 1'b0);
    check("long_no_ferr", 32'(fe_cnt), 32'd1);

    // ws edge coincident with bck rise; right magnitude exactly at threshold
    send_word(1'b0, 16'h0100, 16, 1'b1);
    sb.push_back(mk(16'h0100, 16'hF000));
    send_word(1'b1, 16'hF000, 16, 1'b1);

    // reset in the middle of a left word
    send_word(1'b0, 16'hFFFF, 8, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_left", 32'(audio_left), 32'd0);
    check("mid_rst_right", 32'(audio_right), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_ferr", 32'(frame_err), 32'd0);
    check("mid_rst_voice", 32'(voice), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));

    send_word(1'b1, 16'h0000, 16, 1'b0);
    send_word(1'b0, 16'h7777, 16, 1'b0);
    sb.push_back(mk(16'h7777, 16'h0001));
    send_word(1'b1, 16'h0001, 16, 1'b0);
    send_word(1'b0, 16'h0000, 4, 1'b0);
    tick(20);

    check("final_ferr_count", 32'(fe_cnt), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
